beat_sequencer: RTL and testbench

//  Beat (W1/W2/W3) timing generator and run/stop sequencer for the hardwired controller.

---
 rtl/beat_sequencer_if.sv | 30 +++
 rtl/beat_sequencer.sv | 112 +++++++++++
 tb/tb_beat_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/beat_sequencer_if.sv
// Controller <-> beat sequencer signal bundle. Everything is level-based:
// controller inputs are sampled on every falling T3 and status outputs change only there.
interface beat_sequencer_if #(
  parameter int CNT_W = 16
);
  // No valid/ready pair: each beat line is a registered level that stays valid for one
  // full T3 period, and SHORT/LONG/STOP/STEP must be stable before the falling T3 that
  // ends the beat they refer to.
  logic             QD;
  logic             STEP;
  logic             STOP;
  logic             SHORT;
  logic             LONG;
  logic             W1;
  logic             W2;
  logic             W3;
  logic             RUN;
  logic [CNT_W-1:0] CYC_CNT;
  logic             SEQ_ERR;

  modport master (
    output QD, STEP, STOP, SHORT, LONG,
    input  W1, W2, W3, RUN, CYC_CNT, SEQ_ERR
  );

  modport slave (
    input  QD, STEP, STOP, SHORT, LONG,
    output W1, W2, W3, RUN, CYC_CNT, SEQ_ERR
  );
endinterface

// File: rtl/beat_sequencer.sv
// W1/W2/W3 beat generator and run/stop sequencer; all state advances on falling T3.
// QD starts a run, SHORT/LONG shape each instruction cycle, STOP/STEP end the run.
module beat_sequencer #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              T3,
  input  logic              clr,
  beat_sequencer_if.slave   bus,
  output logic [1:0]        state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   qd_pulse;
  logic                   stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [2:0]             w_q, w_d;
  logic                   run_q, run_d;
  logic                   cyc_end;

  // edge_q remembers the last synchronised level, so a held button gives one pulse
  assign qd_pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_ff @(negedge T3 or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.QD};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    cyc_end     = 1'b0;

    case (state_q)
      IDLE: if (qd_pulse) state_d = B1;
      B1: begin
        if (bus.SHORT) begin
          cyc_end = 1'b1;
          if (bus.LONG) err_d = 1'b1;
        end else begin
          state_d = B2;
        end
      end
      B2: begin
        if (bus.LONG) state_d = B3;
        else          cyc_end = 1'b1;
      end
      B3:      cyc_end = 1'b1;
      default: state_d = IDLE;
    endcase

    // a stop request only arms; the running cycle always completes
    if ((state_q != IDLE) && bus.STOP) stop_pend_d = 1'b1;

    if (cyc_end) begin
      cnt_d = cnt_q + 1'b1;
      if (bus.STOP || stop_pend_q || bus.STEP) begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
      end else begin
        state_d = B1;
      end
    end

    w_d   = {state_d == B3, state_d == B2, state_d == B1};
    run_d = (state_d != IDLE);
  end

  always_ff @(negedge T3 or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      w_q         <= 3'b000;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      w_q         <= w_d;
      run_q       <= run_d;
    end
  end

  assign bus.W1      = w_q[0];
  assign bus.W2      = w_q[1];
  assign bus.W3      = w_q[2];
  assign bus.RUN     = run_q;
  assign bus.CYC_CNT = cnt_q;
  assign bus.SEQ_ERR = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: expected beats are queued per scenario and a
// monitor pops one entry for every beat the sequencer presents while RUN is high.
module tb_beat_sequencer;
  localparam int CW   = 4;
  localparam int SYNC = 2;

  logic       T3;
  logic       clr;
  logic [1:0] state_dbg;
  int         total = 0;
  int         bad   = 0;
  logic [CW+2:0] exp_q[$];

  beat_sequencer_if #(.CNT_W(CW)) bus();

  beat_sequencer #(.CNT_W(CW), .SYNC_STAGES(SYNC)) dut (
    .T3          (T3),
    .clr         (clr),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial T3 = 1'b1;
  always #5 T3 = ~T3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic push_beat(input logic [2:0] w, input int cnt);
    int c;
    logic [CW-1:0] cv;
    c  = cnt % (1 << CW);
    cv = c[CW-1:0];
    exp_q.push_back({w, cv});
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge T3) begin
    logic [CW+2:0] act_w;
    logic [CW+2:0] exp_w;
    if (clr) begin
      act_w = {bus.W3, bus.W2, bus.W1, bus.CYC_CNT};
      total++;
      if (bus.RUN) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got w=%b cnt=%0d expected no beat",
                   act_w[CW+2:CW], act_w[CW-1:0]);
        end else begin
          exp_w = exp_q.pop_front();
          if (act_w !== exp_w) begin
            bad++;
            $display("FAIL beat: got w=%b cnt=%0d expected w=%b cnt=%0d",
                     act_w[CW+2:CW], act_w[CW-1:0], exp_w[CW+2:CW], exp_w[CW-1:0]);
          end
        end
      end else if (act_w[CW+2:CW] !== 3'b000) begin
        bad++;
        $display("FAIL idle_w: got w=%b expected w=000", act_w[CW+2:CW]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // all driver tasks start and end 1 time unit after a rising T3
  task automatic beat(input logic s, input logic l, input logic st);
    bus.SHORT = s;
    bus.LONG  = l;
    bus.STOP  = st;
    @(posedge T3);
    #1;
  endtask

  // press QD (held or one-period tap) and wait for the first W1 beat
  task automatic start_seq(input bit hold);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    bus.QD = 1'b1;
    while (!got && n < 6) begin
      @(posedge T3);
      #1;
      n++;
      if (n == 1 && !hold) bus.QD = 1'b0;
      if (bus.RUN) got = 1'b1;
    end
    total++;
    if (!got || n > SYNC + 2) begin
      bad++;
      $display("FAIL start_latency: got %0d beats (run=%0b) expected <= %0d", n, got, SYNC + 2);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr       = 1'b0;
    bus.QD    = 1'b0;
    bus.STEP  = 1'b0;
    bus.STOP  = 1'b0;
    bus.SHORT = 1'b0;
    bus.LONG  = 1'b0;

    // reset state
    #3;
    check("rst_w",     {13'd0, bus.W3, bus.W2, bus.W1}, 16'd0);
    check("rst_run",   {15'd0, bus.RUN}, 16'd0);
    check("rst_cnt",   {12'd0, bus.CYC_CNT}, 16'd0);
    check("rst_err",   {15'd0, bus.SEQ_ERR}, 16'd0);
    check("rst_state", {14'd0, state_dbg}, 16'd0);
    @(posedge T3);
    #1;
    clr = 1'b1;

    // held QD, SHORT cycles: one start, W1 every beat, count +1 per beat
    for (int i = 0; i < 10; i++) push_beat(3'b001, i);
    bus.SHORT = 1'b1;
    start_seq(1'b1);
    for (int i = 0; i < 9; i++) beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'b0);
    check("held_qd_run", {15'd0, bus.RUN}, 16'd0);
    check("held_qd_cnt", {12'd0, bus.CYC_CNT}, 16'd10);
    bus.QD = 1'b0;
    beat(1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of W2
    push_beat(3'b001, 10);
    push_beat(3'b010, 10);
    start_seq(1'b0);
    beat(1'b0, 1'b0, 1'b0);
    #2;
    clr = 1'b0;
    #1;
    check("mid_rst_w",   {13'd0, bus.W3, bus.W2, bus.W1}, 16'd0);
    check("mid_rst_run", {15'd0, bus.RUN}, 16'd0);
    check("mid_rst_cnt", {12'd0, bus.CYC_CNT}, 16'd0);
    @(posedge T3);
    #1;
    clr = 1'b1;
    beat(1'b0, 1'b0, 1'b0);

    // length mix: SHORT, normal, LONG
    push_beat(3'b001, 0);
    push_beat(3'b001, 1);
    push_beat(3'b010, 1);
    push_beat(3'b001, 2);
    push_beat(3'b010, 2);
    push_beat(3'b100, 2);
    bus.SHORT = 1'b1;
    start_seq(1'b0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b1);
    check("mix_run", {15'd0, bus.RUN}, 16'd0);
    check("mix_cnt", {12'd0, bus.CYC_CNT}, 16'd3);
    beat(1'b0, 1'b0, 1'b0);

    // STOP pulsed in W2 of a LONG cycle: W3 still issued, then idle
    push_beat(3'b001, 3);
    push_beat(3'b010, 3);
    push_beat(3'b100, 3);
    bus.LONG = 1'b1;
    start_seq(1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    check("stop_run", {15'd0, bus.RUN}, 16'd0);
    check("stop_cnt", {12'd0, bus.CYC_CNT}, 16'd4);
    beat(1'b0, 1'b0, 1'b0);

    // single step with a QD press during the cycle that must be discarded
    push_beat(3'b001, 4);
    push_beat(3'b010, 4);
    push_beat(3'b100, 4);
    bus.STEP = 1'b1;
    bus.LONG = 1'b1;
    start_seq(1'b0);
    bus.QD = 1'b1;
    beat(1'b0, 1'b1, 1'b0);
    bus.QD = 1'b0;
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b0, 1'b0);
    check("step_run", {15'd0, bus.RUN}, 16'd0);
    check("step_cnt", {12'd0, bus.CYC_CNT}, 16'd5);
    bus.STEP = 1'b0;

    // counter wrap over 16 SHORT cycles, then SHORT+LONG in W1
    for (int i = 0; i < 18; i++) push_beat(3'b001, 5 + i);
    bus.SHORT = 1'b1;
    start_seq(1'b0);
    for (int i = 0; i < 16; i++) beat(1'b1, 1'b0, 1'b0);
    check("wrap_cnt",    {12'd0, bus.CYC_CNT}, 16'd5);
    check("err_before",  {15'd0, bus.SEQ_ERR}, 16'd0);
    beat(1'b1, 1'b1, 1'b0);
    check("err_set",     {15'd0, bus.SEQ_ERR}, 16'd1);
    check("err_next_w1", {13'd0, bus.W3, bus.W2, bus.W1}, 16'd1);
    beat(1'b1, 1'b0, 1'b1);
    check("err_end_run", {15'd0, bus.RUN}, 16'd0);
    check("err_end_cnt", {12'd0, bus.CYC_CNT}, 16'd7);
    check("err_sticky",  {15'd0, bus.SEQ_ERR}, 16'd1);
    beat(1'b0, 1'b0, 1'b0);

    // only reset clears the sticky error
    clr = 1'b0;
    #1;
    check("err_rst",     {15'd0, bus.SEQ_ERR}, 16'd0);
    @(posedge T3);
    #1;
    clr = 1'b1;
    beat(1'b0, 1'b0, 1'b0);

    check("exp_q_empty", exp_q.size(), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
